// File: rtl/seq_restoring_divider_pkg.sv
// Purpose : shared types and constants for the sequential restoring divider.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package seq_restoring_divider_pkg;

   // Default operand width; also the number of quotient iterations.
   localparam int DEF_WIDTH = 4;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Quotient reported for a divide by zero at the default width.
   localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

   // Iteration counter width: enough to hold WIDTH-1, never less than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Purpose : divide request/response bundle between ALU control and the divider.
// Latency : n/a (wiring only).
// Backpressure : start is only honoured while busy is low; no queuing.
// Ports   : start/A/B from the requester; busy/done/Quotient/Remainder/Div_By_Zero back.
interface seq_restoring_divider_if
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Div_By_Zero;

   // Requester side (ALU control).
   modport master (
      output start, A, B,
      input  busy, done, Quotient, Remainder, Div_By_Zero
   );

   // Divider side.
   modport slave (
      input  start, A, B,
      output busy, done, Quotient, Remainder, Div_By_Zero
   );
endinterface

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Purpose : N-bit combinational a - b as a ripple of full-adder cells (b inverted, carry-in 1).
// Latency : combinational, zero cycles.
// Backpressure : none.
// Ports   : a, b operands; diff = a - b mod 2^N; no_borrow = final carry-out (a >= b).

// Single-bit full adder cell, the same cell the ripple adders are built from.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module trial_subtractor #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         no_borrow
);
   logic [N:0] carry;

   // Carry-in of 1 completes the two's-complement negation of b.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (~b[i]),
         .ci (carry[i]),
         .s  (diff[i]),
         .co (carry[i+1])
      );
   end

   // In the subtract direction a carry-out of 1 means no borrow occurred.
   assign no_borrow = carry[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// Purpose : multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency : done in the cycle after WIDTH+1 edges from acceptance (1 cycle when B==0).
// Backpressure : busy high while working; start ignored unless idle, no queuing.
// Ports   : clk, rst (async, active high); bus = request/response bundle (slave side).
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] dvd;        // dividend, shifted out MSB first
   logic [WIDTH-1:0] dvs;        // latched divisor
   logic [WIDTH-1:0] quo;        // quotient being built, LSB first in
   logic [WIDTH:0]   prem;       // partial remainder, one guard bit
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   prem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             no_borrow;
   logic             last_iter;

   logic [WIDTH-1:0] q_out;
   logic [WIDTH-1:0] r_out;
   logic             dz_out;

   // Trial value: partial remainder shifted left with the next dividend bit.
   assign trial = (prem << 1) | (WIDTH+1)'(dvd[WIDTH-1]);

   trial_subtractor #(
      .N (WIDTH + 1)
   ) u_trial_sub (
      .a         (trial),
      .b         ({1'b0, dvs}),
      .diff      (diff),
      .no_borrow (no_borrow)
   );

   // Restore (keep the trial) when the subtraction would go negative.
   assign prem_nxt  = no_borrow ? diff : trial;
   assign quo_nxt   = (quo << 1) | WIDTH'(no_borrow);
   assign last_iter = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.B == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_nxt = FINISH;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and result registers. Results are loaded on the edge that
   // enters FINISH so they are already valid while done is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd    <= '0;
         dvs    <= '0;
         quo    <= '0;
         prem   <= '0;
         cnt    <= '0;
         q_out  <= '0;
         r_out  <= '0;
         dz_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.B != '0) begin
                     dvd  <= bus.A;
                     dvs  <= bus.B;
                     quo  <= '0;
                     prem <= '0;
                     cnt  <= CW'(WIDTH - 1);
                  end else begin
                     q_out  <= '1;
                     r_out  <= bus.A;
                     dz_out <= 1'b1;
                  end
               end
            end
            RUN: begin
               prem <= prem_nxt;
               quo  <= quo_nxt;
               dvd  <= dvd << 1;
               cnt  <= cnt - 1'b1;
               if (last_iter) begin
                  q_out  <= quo_nxt;
                  // Guard bit is always zero once the last iteration completes.
                  r_out  <= WIDTH'(prem_nxt);
                  dz_out <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == FINISH);
   assign bus.Quotient    = q_out;
   assign bus.Remainder   = r_out;
   assign bus.Div_By_Zero = dz_out;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
   localparam int W = 4;

   logic clk;
   logic rst;

   seq_restoring_divider_if #(.WIDTH(W)) bus ();

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted request occupies the divider for a fixed
   // number of cycles (WIDTH+1, or 1 for a zero divisor); the result appears
   // with done in the last of them and then holds.
   int         m_left;
   logic       m_busy, m_done, m_dz, p_dz;
   logic [3:0] m_q, m_r, p_q, p_r;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_dz   = 1'b0;
      end else begin
         if (m_left != 0) begin
            m_left = m_left - 1;
         end else if (bus.start) begin
            if (bus.B == 0) begin
               p_q    = 4'hF;
               p_r    = bus.A;
               p_dz   = 1'b1;
               m_left = 1;
            end else begin
               p_q    = bus.A / bus.B;
               p_r    = bus.A % bus.B;
               p_dz   = 1'b0;
               m_left = W + 1;
            end
         end
         m_busy = (m_left != 0);
         m_done = (m_left == 1);
         if (m_done) begin
            m_q  = p_q;
            m_r  = p_r;
            m_dz = p_dz;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",        32'(bus.busy),        32'(m_busy));
         chk("done",        32'(bus.done),        32'(m_done));
         chk("quotient",    32'(bus.Quotient),    32'(m_q));
         chk("remainder",   32'(bus.Remainder),   32'(m_r));
         chk("div_by_zero", 32'(bus.Div_By_Zero), 32'(m_dz));
      end
   end

   // Issue one divide and check its latency, busy span and result against
   // hand-computed values. Optionally fires a stray start on cycle 2 and/or
   // checks that the previous result holds until done.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int elat, input bit intr,
                          input bit hold, input logic [3:0] pq, input logic [3:0] pr);
      int lat;
      int busyc;
      bit got;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.A     = 4'($urandom_range(0, 15));
      bus.B     = 4'($urandom_range(0, 15));
      if (intr) begin
         fork
            begin
               @(posedge clk); #1;
               bus.start = 1'b1;
               bus.A     = 4'd1;
               bus.B     = 4'd1;
               @(posedge clk); #1;
               bus.start = 1'b0;
            end
         join_none
      end
      lat   = 0;
      busyc = 0;
      got   = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (bus.busy) busyc++;
         if (bus.done) begin
            got = 1'b1;
            lat = i;
         end else if (hold) begin
            chk("hold_q", 32'(bus.Quotient),  32'(pq));
            chk("hold_r", 32'(bus.Remainder), 32'(pr));
         end
      end
      chk("latency",     32'(lat),   32'(elat));
      chk("busy_cycles", 32'(busyc), 32'(elat));
      chk("lit_q",       32'(bus.Quotient),    32'(eq));
      chk("lit_r",       32'(bus.Remainder),   32'(er));
      chk("lit_dz",      32'(bus.Div_By_Zero), 32'(edz));
   endtask

   initial begin
      int done_seen;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Reset state with no request pending.
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy),        32'd0);
      chk("rst_done", 32'(bus.done),        32'd0);
      chk("rst_q",    32'(bus.Quotient),    32'd0);
      chk("rst_r",    32'(bus.Remainder),   32'd0);
      chk("rst_dz",   32'(bus.Div_By_Zero), 32'd0);

      run_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd2,  4'd9, 4'd0,  4'd2, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd9,  4'd2, 4'd4,  4'd1, 1'b0, 5, 1'b1, 1'b0, 4'd0, 4'd0);
      // Starts in the cycle right after done: must be accepted immediately.
      run_div(4'd12, 4'd4, 4'd3,  4'd0, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      run_div(4'd14, 4'd5, 4'd2,  4'd4, 1'b0, 5, 1'b0, 1'b1, 4'd3, 4'd0);

      // Reset in the middle of RUN: outputs clear at once, no done follows.
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.A     = 4'd13;
      bus.B     = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy),        32'd0);
      chk("arst_done", 32'(bus.done),        32'd0);
      chk("arst_q",    32'(bus.Quotient),    32'd0);
      chk("arst_r",    32'(bus.Remainder),   32'd0);
      chk("arst_dz",   32'(bus.Div_By_Zero), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      chk("no_done_after_abort", 32'(done_seen), 32'd0);

      // Random traffic, including starts held through busy and done.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.start = ($urandom_range(0, 2) == 0);
         bus.A     = 4'($urandom_range(0, 15));
         bus.B     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
      $fatal(1);
   end

endmodule
